ldtu_out_fifo: RTL and testbench
================================

# ldtu_out_fifo

Output buffer directly downstream of the LiteDTU control unit. It stores the 32-bit words the control unit writes (samples, fallback words, frame trailers) in a 64-deep circular buffer and returns a registered `full` flag that the control unit uses for back-pressure. Words are released to the serializer side one per `read_signal` pulse; an idle pattern is presented whenever nothing valid is available. It also counts writes dropped on overflow, for monitoring.

## Interface
Parameters:
- `Nbits_32`, 32, word width
- `FifoDepth_buff`, 64, number of entries (power of two)
- `bits_ptr`, 6, pointer width, log2(`FifoDepth_buff`)
- `FullMargin`, 2, free-entry margin at which `full` asserts; covers the control unit's one-cycle write latency
- `Idle`, 32'hEAAAAAAA, word driven on `DATA_out` when no valid data

Ports:
- `CLK`, in, 1, single clock; all logic on its rising edge
- `rst_b`, in, 1, reset; synchronous, active-low
- `write_signal`, in, 1, write strobe from the control unit
- `DATA_from_CU`, in, `Nbits_32`, write data, sampled when `write_signal`=1
- `read_signal`, in, 1, read request from the serializer handshake
- `full`, out, 1, registered back-pressure flag to the control unit
- `empty`, out, 1, registered; 1 when occupancy is 0
- `DATA_out`, out, `Nbits_32`, registered read data
- `data_valid`, out, 1, registered; 1 in the cycle after a successful read
- `level`, out, `bits_ptr`+1, current occupancy, 0..64
- `overflow_cnt`, out, 8, count of dropped writes; saturates at 255

## Operation
- Storage is `FifoDepth_buff` x `Nbits_32`. The memory array is not reset.
- State: `wr_ptr` and `rd_ptr` (`bits_ptr` bits each, wrap modulo 64) and `count` (`bits_ptr`+1 bits).
- Write accepted: `write_signal`=1 and `count` < 64.
  - Store the word at `wr_ptr`, then increment `wr_ptr`.
- Write dropped: `write_signal`=1 and `count`=64.
  - Memory and pointers unchanged.
  - `overflow_cnt` increments; it saturates at 255 and never wraps.
- Read accepted: `read_signal`=1 and `count` > 0.
  - `DATA_out` <= mem[`rd_ptr`], `rd_ptr` increments, `data_valid` <= 1.
- Read on empty, or no read: `DATA_out` <= `Idle`, `data_valid` <= 0.
  - There is no underflow state; pointers are unchanged.
- Simultaneous write and read:
  - Both are evaluated against the pre-edge `count`.
  - If both are accepted, `count` is unchanged.
  - At `count`=0 the read is not accepted: the output is `Idle` and the written word is stored (no fall-through).
  - At `count`=64 the read is accepted and the write is dropped, because acceptance uses the pre-edge count.
- Flags are computed from next-state count (`count_next`) and registered:
  - `full` <= (`count_next` >= 64 − `FullMargin`), i.e. asserted at occupancy 62.
  - `empty` <= (`count_next` = 0).
- `level` = `count`, driven directly from the register.
- Reset values: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `full`=0, `empty`=1, `DATA_out`=`Idle`, `data_valid`=0, `level`=0, `overflow_cnt`=0.
- Reset mid-operation: all buffered content is discarded and `overflow_cnt` is cleared. A `write_signal` or `read_signal` in the reset cycle is ignored.

## Timing
- Write to readable: a word written at edge N can be read by a `read_signal` sampled at edge N+1.
- Read latency: `read_signal` sampled at edge N gives `DATA_out`/`data_valid` valid after edge N, for one cycle.
- Back-to-back reads give one word per cycle until empty; `data_valid` drops in the cycle after the last word.
- Flag timing: `full`/`empty` reflect the state after edge N in the cycle following edge N.
  - The control unit registers its write one cycle after sampling `full`.
  - With `FullMargin`=2, at most 2 writes can land after `full` asserts. No data is lost under compliant use.
- Throughput: one write and one read per cycle, sustained.

## Test plan
- Reset: hold `rst_b`=0 for 2 cycles with strobes toggling -> `DATA_out`=32'hEAAAAAAA, `empty`=1, `full`=0, `level`=0, `overflow_cnt`=0.
- Single word: write 32'h12345678, then `read_signal` next cycle -> `DATA_out`=32'h12345678 with `data_valid`=1; next cycle `Idle`, `data_valid`=0, `empty`=1.
- Fill/overflow: 66 consecutive writes of values 0..65, no reads.
  - `full` rises in the cycle after the 62nd write.
  - `level`=64 after the 64th write; `overflow_cnt`=2 at the end.
  - 64 reads then return 0..63 in order.
- Wrap-around: 100 writes and 100 reads interleaved with the buffer kept at occupancy 10 -> all words returned in order across pointer wrap; `level` stays at 10.
- Simultaneous events:
  - Read+write at `count`=0 -> `Idle` out, `level`=1.
  - Read+write at `count`=64 -> oldest word out, write dropped, `overflow_cnt`+1, `level`=63.
- Reset mid-operation: with `level`=20, pulse `rst_b` low for 1 cycle -> `level`=0, `empty`=1; the next read returns `Idle`.

Source files
------------

// File: rtl/ldtu_out_fifo.sv
// ldtu_out_fifo: 64-deep output buffer with registered full/empty flags, idle fill and an overflow counter
module ldtu_out_fifo #(
  parameter int Nbits_32 = 32,
  parameter int FifoDepth_buff = 64,
  parameter int bits_ptr = 6,
  parameter int FullMargin = 2,
  parameter logic [Nbits_32-1:0] Idle = 32'hEAAAAAAA
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                write_signal,
  input  logic [Nbits_32-1:0] DATA_from_CU,
  input  logic                read_signal,
  output logic                full,
  output logic                empty,
  output logic [Nbits_32-1:0] DATA_out,
  output logic                data_valid,
  output logic [bits_ptr:0]   level,
  output logic [7:0]          overflow_cnt
);
  localparam logic [bits_ptr:0] depth_c = (bits_ptr+1)'(FifoDepth_buff);
  localparam logic [bits_ptr:0] full_th_c = (bits_ptr+1)'(FifoDepth_buff - FullMargin);
  logic [Nbits_32-1:0] mem [FifoDepth_buff];
  logic [bits_ptr-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [bits_ptr:0]   count_q, count_d;
  logic                full_q, full_d, empty_q, empty_d, valid_q, valid_d;
  logic [Nbits_32-1:0] data_q, data_d;
  logic [7:0]          ovf_q, ovf_d;
  logic                wr_acc, rd_acc;
  always_comb begin
    wr_acc   = write_signal && (count_q != depth_c);
    rd_acc   = read_signal && (count_q != '0);
    wr_ptr_d = wr_ptr_q + bits_ptr'(wr_acc);
    rd_ptr_d = rd_ptr_q + bits_ptr'(rd_acc);
    count_d  = count_q + (bits_ptr+1)'(wr_acc) - (bits_ptr+1)'(rd_acc);
    full_d   = count_d >= full_th_c;
    empty_d  = count_d == '0;
    data_d   = rd_acc ? mem[rd_ptr_q] : Idle;
    valid_d  = rd_acc;
    ovf_d    = (write_signal && !wr_acc && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
  end
  always_ff @(posedge CLK) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      data_q   <= Idle;
      valid_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (rst_b && wr_acc) mem[wr_ptr_q] <= DATA_from_CU;
  end
  assign full         = full_q;
  assign empty        = empty_q;
  assign DATA_out     = data_q;
  assign data_valid   = valid_q;
  assign level        = count_q;
  assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_ldtu_out_fifo.sv
// tb_ldtu_out_fifo: directed stimulus with a scoreboard queue checked by an independent output monitor
module tb_ldtu_out_fifo;
  localparam logic [31:0] idle_c = 32'hEAAAAAAA;
  logic        CLK = 1'b0;
  logic        rst_b = 1'b0;
  logic        write_signal = 1'b0;
  logic [31:0] DATA_from_CU = '0;
  logic        read_signal = 1'b0;
  logic        full, empty, data_valid;
  logic [31:0] DATA_out;
  logic [6:0]  level;
  logic [7:0]  overflow_cnt;
  logic [31:0] sb [$];
  logic        mon_en = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  ldtu_out_fifo dut (
    .CLK(CLK), .rst_b(rst_b), .write_signal(write_signal), .DATA_from_CU(DATA_from_CU),
    .read_signal(read_signal), .full(full), .empty(empty), .DATA_out(DATA_out),
    .data_valid(data_valid), .level(level), .overflow_cnt(overflow_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic w, input logic [31:0] d, input logic r);
    write_signal = w;
    DATA_from_CU = d;
    read_signal = r;
    @(posedge CLK);
    #1;
    write_signal = 1'b0;
    read_signal = 1'b0;
  endtask
  always @(negedge CLK) begin
    if (mon_en) begin
      if (data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", DATA_out, idle_c);
        end else begin
          chk("sb_data", DATA_out, sb.pop_front());
        end
      end else begin
        chk("idle_out", DATA_out, idle_c);
        chk("valid_low", {31'b0, data_valid}, 32'd0);
      end
    end
  end
  initial begin
    @(posedge CLK);
    #1;
    step(1'b1, 32'hDEADBEEF, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("rst_data", DATA_out, idle_c);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_level", {25'b0, level}, 32'd0);
    chk("rst_ovf", {24'b0, overflow_cnt}, 32'd0);
    chk("rst_valid", {31'b0, data_valid}, 32'd0);
    rst_b = 1'b1;
    mon_en = 1'b1;
    step(1'b1, 32'h12345678, 1'b0);
    chk("single_level", {25'b0, level}, 32'd1);
    chk("single_nempty", {31'b0, empty}, 32'd0);
    sb.push_back(32'h12345678);
    step(1'b0, 32'h0, 1'b1);
    chk("single_valid", {31'b0, data_valid}, 32'd1);
    step(1'b0, 32'h0, 1'b0);
    chk("single_after_valid", {31'b0, data_valid}, 32'd0);
    chk("single_after_idle", DATA_out, idle_c);
    chk("single_after_empty", {31'b0, empty}, 32'd1);
    for (int i = 0; i < 66; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 60) chk("full_before_62", {31'b0, full}, 32'd0);
      if (i == 61) chk("full_at_62", {31'b0, full}, 32'd1);
      if (i == 63) chk("level_64", {25'b0, level}, 32'd64);
    end
    chk("fill_level", {25'b0, level}, 32'd64);
    chk("fill_ovf", {24'b0, overflow_cnt}, 32'd2);
    chk("fill_full", {31'b0, full}, 32'd1);
    for (int i = 0; i < 64; i++) begin
      sb.push_back(32'(i));
      step(1'b0, 32'h0, 1'b1);
    end
    chk("drain_empty", {31'b0, empty}, 32'd1);
    chk("drain_full", {31'b0, full}, 32'd0);
    chk("drain_level", {25'b0, level}, 32'd0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(1000 + i), 1'b0);
    for (int i = 0; i < 100; i++) begin
      sb.push_back(32'(1000 + i));
      step(1'b1, 32'(1010 + i), 1'b1);
      chk("wrap_level", {25'b0, level}, 32'd10);
    end
    for (int i = 0; i < 10; i++) begin
      sb.push_back(32'(1100 + i));
      step(1'b0, 32'h0, 1'b1);
    end
    chk("wrap_empty", {31'b0, empty}, 32'd1);
    step(1'b1, 32'hAAAA0001, 1'b1);
    chk("rw0_level", {25'b0, level}, 32'd1);
    chk("rw0_data", DATA_out, idle_c);
    chk("rw0_valid", {31'b0, data_valid}, 32'd0);
    sb.push_back(32'hAAAA0001);
    step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 64; i++) step(1'b1, 32'(2000 + i), 1'b0);
    sb.push_back(32'd2000);
    step(1'b1, 32'h00000BAD, 1'b1);
    chk("rw64_level", {25'b0, level}, 32'd63);
    chk("rw64_ovf", {24'b0, overflow_cnt}, 32'd3);
    for (int i = 1; i < 64; i++) begin
      sb.push_back(32'(2000 + i));
      step(1'b0, 32'h0, 1'b1);
    end
    chk("rw64_empty", {31'b0, empty}, 32'd1);
    for (int i = 0; i < 20; i++) step(1'b1, 32'(3000 + i), 1'b0);
    chk("mid_level20", {25'b0, level}, 32'd20);
    rst_b = 1'b0;
    step(1'b1, 32'h55555555, 1'b0);
    rst_b = 1'b1;
    chk("mid_level", {25'b0, level}, 32'd0);
    chk("mid_empty", {31'b0, empty}, 32'd1);
    chk("mid_ovf", {24'b0, overflow_cnt}, 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("mid_read_idle", DATA_out, idle_c);
    chk("mid_read_valid", {31'b0, data_valid}, 32'd0);
    for (int i = 0; i < 64 + 254; i++) begin
      step(1'b1, 32'(i), 1'b0);
      if (i == 64 + 253) chk("ovf_254", {24'b0, overflow_cnt}, 32'd254);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i), 1'b0);
    chk("ovf_sat", {24'b0, overflow_cnt}, 32'd255);
    chk("ovf_level", {25'b0, level}, 32'd64);
    @(negedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
